// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Purpose : Shared types and constants for the data-memory controller:
//           FSM state encoding, latched operation encoding, the byte-to-word
//           address shift and the wait-counter width helper.
// Revision: 1.0 - initial release
// ============================================================================
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_ILLEGAL = 2'd2
  } op_t;

  // Byte address bits below this position select a byte within a word.
  localparam int WORD_LSB = 2;

  // A 4-bit counter covers the full 0..15 range of wait states; wider
  // settings would grow the counter accordingly.
  function automatic int wait_cnt_width(input int max_wait);
    return (max_wait <= 15) ? 4 : $clog2(max_wait + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_sram.sv
`default_nettype none
// ============================================================================
// Module  : dmem_sram
// Purpose : Single-port synchronous word RAM with registered read data.
//           A read updates rdata only on an enabled, non-write cycle, so
//           rdata keeps the most recent read value across writes.
// Ports   : clk   - clock, rising edge
//           we    - write enable (qualified by en)
//           en    - access enable
//           addr  - word index
//           wdata - write data
//           rdata - registered read data
// Revision: 1.0 - initial release
// ============================================================================
module dmem_sram #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic                           en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [DATA_W-1:0]              wdata,
  output logic [DATA_W-1:0]              rdata
);

  // Storage has no reset; contents survive a controller reset.
  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_controller.sv
`default_nettype none
// ============================================================================
// Module  : dmem_controller
// Purpose : Data-memory controller behind the pipeline MEM stage. Captures a
//           load/store request, checks its legality, inserts WAIT_CYCLES
//           wait states, performs the RAM access and answers with a one-cycle
//           completion (or error) pulse. mem_busy stalls the pipeline from
//           the request cycle until the response cycle.
// Ports   : clk, rst                          - clock / async active-high reset
//           read, write                       - request strobes from MEM stage
//           memory_addr                       - byte address
//           data_to_write                     - store data
//           read_data_from_memory_controller  - load data, held until next load
//           mem_busy                          - stall request (combinational)
//           mem_done                          - completion pulse
//           addr_error                        - rejected-request pulse
// Revision: 1.0 - initial release
// ============================================================================
module dmem_controller
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] memory_addr,
  input  logic [DATA_W-1:0] data_to_write,
  output logic [DATA_W-1:0] read_data_from_memory_controller,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              addr_error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = wait_cnt_width(WAIT_CYCLES);

  state_t              state;
  op_t                 op_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt;
  logic                rdata_zero;

  logic                req;
  logic                req_illegal;
  op_t                 req_op;
  logic [IDX_W-1:0]    req_idx;
  logic                acc_now;
  logic                ram_we;
  logic [IDX_W-1:0]    ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;

  assign req     = read | write;
  assign req_idx = memory_addr[WORD_LSB+IDX_W-1:WORD_LSB];

  // Depth is a power of two, so "word index >= DEPTH_WORDS" is simply any
  // address bit set above the RAM index field.
  always_comb begin
    req_illegal = (read & write)
                | (memory_addr[WORD_LSB-1:0] != '0)
                | (|memory_addr[ADDR_W-1:WORD_LSB+IDX_W]);
    if (req_illegal) begin
      req_op = OP_ILLEGAL;
    end else if (write) begin
      req_op = OP_WRITE;
    end else begin
      req_op = OP_READ;
    end
  end

  // The RAM access happens either at the capture edge (zero wait states,
  // straight from the inputs) or at the last WAIT edge (from the latches).
  always_comb begin
    acc_now = 1'b0;
    if (!rst) begin
      if (state == IDLE) begin
        acc_now = req & ~req_illegal & (WAIT_CYCLES == 0);
      end else if (state == WAIT) begin
        acc_now = (cnt == '0);
      end
    end
    if (state == IDLE) begin
      ram_we    = write;
      ram_addr  = req_idx;
      ram_wdata = data_to_write;
    end else begin
      ram_we    = (op_q == OP_WRITE);
      ram_addr  = idx_q;
      ram_wdata = wdata_q;
    end
  end

  dmem_sram #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk   (clk),
    .we    (ram_we),
    .en    (acc_now),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The RAM read register cannot be reset, so a flag masks it to zero from
  // reset until the first completed legal load.
  assign read_data_from_memory_controller = rdata_zero ? '0 : ram_rdata;

  assign mem_busy = ~rst & ((state == WAIT) | ((state == IDLE) & req));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= OP_READ;
      idx_q      <= '0;
      wdata_q    <= '0;
      mem_done   <= 1'b0;
      addr_error <= 1'b0;
      rdata_zero <= 1'b1;
    end else begin
      mem_done   <= 1'b0;
      addr_error <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            op_q    <= req_op;
            idx_q   <= req_idx;
            wdata_q <= data_to_write;
            if (req_illegal) begin
              addr_error <= 1'b1;
              state      <= RESP;
            end else if (WAIT_CYCLES == 0) begin
              mem_done <= 1'b1;
              state    <= RESP;
              if (!write) begin
                rdata_zero <= 1'b0;
              end
            end else begin
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            mem_done <= 1'b1;
            state    <= RESP;
            if (op_q == OP_READ) begin
              rdata_zero <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // Request still held by the completing instruction is ignored here.
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_controller
// Purpose : Self-checking bench for dmem_controller. Two instances run side by
//           side, one with zero wait states and one with two, sharing clock
//           and reset. Directed table vectors, hand-written multi-cycle
//           sequences and random transactions against a word-array model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_s   [2];
  logic        wr_s   [2];
  logic [31:0] addr_s [2];
  logic [31:0] wdat_s [2];
  logic [31:0] rdata_o[2];
  logic        busy_o [2];
  logic        done_o [2];
  logic        err_o  [2];

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_m [2][1024];
  logic [31:0] rd_m  [2];

  always #5 clk = ~clk;

  dmem_controller #(.WAIT_CYCLES(0)) dut_w0 (
    .clk                              (clk),
    .rst                              (rst),
    .read                             (rd_s[0]),
    .write                            (wr_s[0]),
    .memory_addr                      (addr_s[0]),
    .data_to_write                    (wdat_s[0]),
    .read_data_from_memory_controller (rdata_o[0]),
    .mem_busy                         (busy_o[0]),
    .mem_done                         (done_o[0]),
    .addr_error                       (err_o[0])
  );

  dmem_controller #(.WAIT_CYCLES(2)) dut_w2 (
    .clk                              (clk),
    .rst                              (rst),
    .read                             (rd_s[1]),
    .write                            (wr_s[1]),
    .memory_addr                      (addr_s[1]),
    .data_to_write                    (wdat_s[1]),
    .read_data_from_memory_controller (rdata_o[1]),
    .mem_busy                         (busy_o[1]),
    .mem_done                         (done_o[1]),
    .addr_error                       (err_o[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: legality rules and word-array memory.
  task automatic model(input int d, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, output bit e, output logic [31:0] r);
    e = (rd && wr) || (a % 4 != 0) || (a / 4 >= 1024);
    if (!e) begin
      if (wr) mem_m[d][a / 4] = wd;
      else    rd_m[d] = mem_m[d][a / 4];
    end
    r = rd_m[d];
  endtask

  // One complete transaction with per-cycle checks of the handshake.
  task automatic txn(input int d, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input bit exp_err, input logic [31:0] exp_rd,
                     input string tag);
    int last;
    last = exp_err ? 1 : ((d == 0) ? 1 : 3);
    @(negedge clk);
    rd_s[d] = rd; wr_s[d] = wr; addr_s[d] = a; wdat_s[d] = wd;
    #1 chk({tag, " busy@req"}, 32'(busy_o[d]), 32'd1);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == last) begin
        chk({tag, " done"},  32'(done_o[d]), 32'(!exp_err));
        chk({tag, " err"},   32'(err_o[d]),  32'(exp_err));
        chk({tag, " busy@resp"}, 32'(busy_o[d]), 32'd0);
        chk({tag, " rdata"}, rdata_o[d], exp_rd);
      end else begin
        chk({tag, " busy@wait"}, 32'(busy_o[d]), 32'd1);
        chk({tag, " done@wait"}, 32'(done_o[d]), 32'd0);
        chk({tag, " err@wait"},  32'(err_o[d]),  32'd0);
      end
      if (k == 1) begin
        // Scramble inputs: the latched request must be what completes.
        rd_s[d] = 1'b0; wr_s[d] = 1'b0; addr_s[d] = $urandom; wdat_s[d] = $urandom;
      end
    end
    @(negedge clk);
    chk({tag, " done@idle"}, 32'(done_o[d]), 32'd0);
    chk({tag, " err@idle"},  32'(err_o[d]),  32'd0);
    chk({tag, " busy@idle"}, 32'(busy_o[d]), 32'd0);
  endtask

  typedef struct {
    int          d;
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    bit          err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[13];

  initial begin
    bit          e;
    logic [31:0] r;
    logic [7:0]  exp_done_pat;
    logic [7:0]  exp_busy_pat;
    int          dones;
    int          d, kind, w;
    bit          rd, wr;
    logic [31:0] a, wd;

    for (int i = 0; i < 2; i++) begin
      rd_m[i] = '0;
      for (int j = 0; j < 1024; j++) mem_m[i][j] = '0;
      rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = '0; wdat_s[i] = '0;
    end

    tbl[0]  = '{1, 1'b0, 1'b1, 32'h10,   32'h12345678, 1'b0, 32'h0};
    tbl[1]  = '{1, 1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 32'h12345678};
    tbl[2]  = '{0, 1'b0, 1'b1, 32'h0,    32'hDEADBEEF, 1'b0, 32'h0};
    tbl[3]  = '{0, 1'b1, 1'b0, 32'h0,    32'h0,        1'b0, 32'hDEADBEEF};
    tbl[4]  = '{0, 1'b1, 1'b0, 32'h13,   32'h0,        1'b1, 32'hDEADBEEF};
    tbl[5]  = '{1, 1'b0, 1'b1, 32'h1000, 32'h55555555, 1'b1, 32'h12345678};
    tbl[6]  = '{1, 1'b1, 1'b0, 32'hFFC,  32'h0,        1'b0, 32'h0};
    tbl[7]  = '{1, 1'b1, 1'b0, 32'h0,    32'h0,        1'b0, 32'h0};
    tbl[8]  = '{1, 1'b1, 1'b1, 32'h10,   32'hFFFFFFFF, 1'b1, 32'h0};
    tbl[9]  = '{1, 1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 32'h12345678};
    tbl[10] = '{0, 1'b0, 1'b1, 32'h8,    32'hCAFEF00D, 1'b0, 32'hDEADBEEF};
    tbl[11] = '{0, 1'b1, 1'b0, 32'h8,    32'h0,        1'b0, 32'hCAFEF00D};
    tbl[12] = '{0, 1'b1, 1'b0, 32'hFFC,  32'h0,        1'b0, 32'h0};

    // Reset, with a request pending to show mem_busy is forced low.
    rst = 1'b1;
    rd_s[0] = 1'b1; wr_s[1] = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset busy",  32'(busy_o[i]), 32'd0);
      chk("reset done",  32'(done_o[i]), 32'd0);
      chk("reset err",   32'(err_o[i]),  32'd0);
      chk("reset rdata", rdata_o[i],     32'd0);
    end
    rd_s[0] = 1'b0; wr_s[1] = 1'b0;
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      model(tbl[i].d, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, e, r);
      txn(tbl[i].d, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].err, tbl[i].exp_rd,
          $sformatf("vec%0d", i));
    end

    // Reset during WAIT of a store: store is aborted, outputs drop at once.
    @(negedge clk);
    wr_s[1] = 1'b1; addr_s[1] = 32'h20; wdat_s[1] = 32'hAAAAAAAA;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst busy",   32'(busy_o[1]), 32'd0);
    chk("midrst done",   32'(done_o[1]), 32'd0);
    chk("midrst err",    32'(err_o[1]),  32'd0);
    chk("midrst rdata1", rdata_o[1],     32'd0);
    chk("midrst rdata0", rdata_o[0],     32'd0);
    @(negedge clk);
    rst = 1'b0; wr_s[1] = 1'b0;
    rd_m[0] = '0; rd_m[1] = '0;
    model(1, 1'b1, 1'b0, 32'h20, 32'h0, e, r);
    txn(1, 1'b1, 1'b0, 32'h20, 32'h0, e, r, "after_rst_rd");

    // Held read at 0x4 through RESP: exactly two transactions.
    model(1, 1'b1, 1'b0, 32'h4, 32'h0, e, r);
    model(1, 1'b1, 1'b0, 32'h4, 32'h0, e, r);
    exp_done_pat = 8'b0100_0100;
    exp_busy_pat = 8'b0011_1011;
    dones = 0;
    @(negedge clk);
    rd_s[1] = 1'b1; wr_s[1] = 1'b0; addr_s[1] = 32'h4;
    #1 chk("held busy@req", 32'(busy_o[1]), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("held done c%0d", k), 32'(done_o[1]), 32'(exp_done_pat[k-1]));
      chk($sformatf("held busy c%0d", k), 32'(busy_o[1]), 32'(exp_busy_pat[k-1]));
      if (done_o[1]) begin
        dones++;
        chk($sformatf("held rdata c%0d", k), rdata_o[1], r);
      end
      if (k == 7) rd_s[1] = 1'b0;
    end
    chk("held done count", 32'(dones), 32'd2);

    // Random transactions against the model.
    for (int i = 0; i < 160; i++) begin
      d    = $urandom_range(0, 1);
      kind = $urandom_range(0, 9);
      w    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(1016, 1023);
      a    = 32'(w) << 2;
      wd   = $urandom;
      rd   = ($urandom_range(0, 1) == 1);
      wr   = !rd;
      case (kind)
        0: begin rd = 1'b1; wr = 1'b1; end
        1: a = a | 32'($urandom_range(1, 3));
        2: a = 32'($urandom_range(1024, 1 << 20)) << 2;
        default: ;
      endcase
      model(d, rd, wr, a, wd, e, r);
      txn(d, rd, wr, a, wd, e, r, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_controller.md
Name: dmem_controller

Overview:
- Data-memory controller sitting directly downstream of the pipeline MEM stage (memfull).
- Consumes its request signals (read, write, memory_addr, data_to_write) and returns read_data_from_memory_controller.
- Models a word-addressed data RAM with a configurable number of wait states.
- Drives a stall signal so the pipeline holds the MEM stage until the access completes.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 32, byte address width
- DEPTH_WORDS, 1024, number of RAM words; power of two
- WAIT_CYCLES, 2, extra cycles per access; legal range 0..15

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- read  input  1  load request from MEM stage
- write  input  1  store request from MEM stage
- memory_addr  input  ADDR_W  byte address
- data_to_write  input  DATA_W  store data
- read_data_from_memory_controller  output  DATA_W  registered load data
- mem_busy  output  1  stall request to pipeline
- mem_done  output  1  one-cycle completion pulse
- addr_error  output  1  one-cycle pulse on a rejected request

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - State goes to IDLE, wait counter to 0.
  - read_data_from_memory_controller=0, mem_done=0, addr_error=0.
  - mem_busy is forced 0 while rst=1.
  - RAM contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE, no request (read=0, write=0): stay in IDLE, mem_busy=0.
- IDLE, request: mem_busy=1 combinationally in the same cycle. On the clock edge, the controller:
  - Latches op, address and write data.
  - Checks legality:
    - Illegal if read=1 and write=1 together.
    - Illegal if memory_addr[1:0]!=0.
    - Illegal if word index memory_addr[ADDR_W-1:2] >= DEPTH_WORDS.
  - If illegal: goes to RESP with addr_error=1, performs no RAM access and leaves the read data register unchanged.
  - If legal and WAIT_CYCLES=0: performs the access at this edge and goes to RESP.
  - If legal and WAIT_CYCLES>0: loads counter=WAIT_CYCLES-1 and goes to WAIT.
- WAIT: mem_busy=1.
  - Counter decrements each cycle.
  - At the edge where counter==0, performs the access and goes to RESP.
  - Inputs are ignored while in WAIT; the latched request is used.
- Access rules:
  - Write stores the latched data at the latched word.
  - Read loads RAM[word] into read_data_from_memory_controller at the same edge.
  - The read data register holds its value until the next completed legal read.
- RESP (exactly one cycle):
  - mem_done=1, mem_busy=0, so the pipeline advances at this edge.
  - The still-asserted request from the completing instruction is ignored.
  - Next state is IDLE.
- Latency: capture edge to mem_done high is WAIT_CYCLES+1 cycles.
  - Back-to-back requests cost WAIT_CYCLES+2 cycles each.
- Read-after-write to the same address returns the new data, because the writes are in separate transactions.
- Reset mid-operation (asserted in WAIT): the transaction is aborted.
  - No RAM write, no mem_done, read data goes to 0.
- mem_done and addr_error are never high outside RESP.
- mem_busy and mem_done are never high together.
- The address is a byte address; only bits [log2(DEPTH_WORDS)+1:2] index the RAM. The upper-bit range check still applies.

Decomposition:
- Package dmem_pkg holds:
  - State enum (IDLE, WAIT, RESP).
  - Op enum (OP_READ, OP_WRITE, OP_ILLEGAL).
  - Constant WORD_LSB=2.
  - Width function for the wait counter (4 bits).
- Sub-module dmem_sram:
  - Single-port synchronous RAM with DATA_W and DEPTH_WORDS parameters.
  - Ports: clk, we, en, addr, wdata, rdata.
  - Registered read, no reset, initialised to 0 in simulation.
- The FSM, counter, legality check and output registers live in dmem_controller.

Test Plan:
- Write then read, WAIT_CYCLES=2: write 0x12345678 to 0x10, then read 0x10.
  - Required: mem_busy high for 3 cycles per request and mem_done pulses 3 cycles after each capture edge.
  - Required: read data is 0x12345678 at the read's mem_done.
- Zero wait, WAIT_CYCLES=0: read 0x0 after writing 0xDEADBEEF there.
  - Required: mem_done one cycle after the capture edge, data 0xDEADBEEF.
- Misaligned: read at 0x13 while read data holds 0xDEADBEEF.
  - Required: addr_error pulse one cycle after capture, no mem_done, read data stays 0xDEADBEEF.
- Out of range and illegal op:
  - Write to 0x1000 (word 1024) gives addr_error, and a read of 0xFFC is unchanged.
  - read=write=1 gives addr_error and no RAM change.
- Reset mid-write: write 0xAAAAAAAA to 0x20, then assert rst during WAIT for one cycle.
  - Required: outputs go to 0 immediately.
  - Required: a later read of 0x20 returns the prior value (0x0).
- Held request: keep read=1 at 0x4 through RESP and into the next cycle.
  - Required: exactly two transactions, each with a single mem_done pulse, and no double capture within RESP.
